// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM encoding, port indices and default widths for the dmem arbiter.
package dmem_arb_pkg;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_RESP = 2'd3} state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and dmem-side signals of the dmem arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [1:0]        req;
    logic [1:0]        req_wren;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    modport master (
        output req, req_wren, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_q,
        input  gnt, rvalid, rdata, mem_address, mem_data, mem_wren
    );
    modport slave (
        input  req, req_wren, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_q,
        output gnt, rvalid, rdata, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; with last tied to 1 it degenerates to port-0 priority.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);
    assign win = &req ? ~last : req[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serializes cpu/debug accesses onto the single-port dmem with registered drive.
// Define DMEM_ARB_FIXED_PRIO_EN for strict port-0 priority instead of round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] RESP  = ST_RESP;

    logic [1:0]        state;
    logic              sel;
    logic              win;
    logic              last;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rvalid;

    rr_arb2 u_arb (.req(bus.req), .last(last), .win(win));

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign last = PORT_DBG;
`else
    always_ff @(posedge clock)
        if (reset) last <= PORT_DBG;
        else if (state == IDLE && |bus.req) last <= win;
`endif

    // The winner's request is captured on the arbitration edge so dmem sees registered signals.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            sel    <= PORT_CPU;
            wren   <= 1'b0;
            addr   <= '0;
            data   <= '0;
            rdata  <= '0;
            rvalid <= 2'b00;
        end else begin
            rvalid <= 2'b00;
            case (state)
                IDLE: if (|bus.req) begin
                    state <= ISSUE;
                    sel   <= win;
                    wren  <= bus.req_wren[win];
                    addr  <= win ? bus.req_addr1 : bus.req_addr0;
                    data  <= win ? bus.req_wdata1 : bus.req_wdata0;
                end
                ISSUE: begin
                    state <= wren ? IDLE : WAIT;
                    wren  <= 1'b0;
                end
                WAIT: begin
                    state  <= RESP;
                    rdata  <= bus.mem_q;
                    rvalid <= sel ? 2'b10 : 2'b01;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = state == ISSUE ? (sel == PORT_DBG ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rvalid      = rvalid;
    assign bus.rdata       = rdata;
    assign bus.mem_address = addr;
    assign bus.mem_data    = data;
    assign bus.mem_wren    = wren;
endmodule
